// File: rtl/stb_gen_avg.sv
// Strobe generator: averages 2**AVG_LOG2 periods of an async input, then emits a free-running
// strobe at that period with a programmable low window, re-measuring in the background.
module stb_gen_avg #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2**20
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 sig_i,
  input  logic                 en_i,
  input  logic                 oe_i,
  input  logic [CNT_WIDTH-1:0] hold_i,
  output logic                 rdy_o,
  output logic                 err_o,
  output logic                 stb_o,
  output logic [CNT_WIDTH-1:0] stb_period_o
);

  localparam int unsigned SumW = CNT_WIDTH + AVG_LOG2;
  localparam int unsigned EcW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [EcW-1:0]       EcLast    = EcW'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax    = '1;
  localparam logic [CNT_WIDTH-1:0] TimeoutM1 = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH:0]   HoldMarg  = (CNT_WIDTH+1)'(2);

  typedef enum logic [2:0] {StIdle, StSkip, StMeas, StCalc, StRun, StErr} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_WIDTH-1:0]   per_cnt_q;
  logic [SumW-1:0]        sum_q;
  logic [EcW-1:0]         edge_cnt_q;
  logic [CNT_WIDTH-1:0]   ph_cnt_q;
  logic [CNT_WIDTH-1:0]   stb_period_q;
  logic [CNT_WIDTH-1:0]   pend_q;
  logic                   pend_valid_q;
  logic                   rdy_q;
  logic                   err_q;
  logic                   stb_q;

  logic                   sig_edge;
  logic [SumW-1:0]        blk_sum;
  logic [CNT_WIDTH-1:0]   blk_avg;
  logic [CNT_WIDTH-1:0]   calc_avg;
  logic [CNT_WIDTH:0]     hold_min;
  logic                   calc_short;
  logic                   blk_short;
  logic                   blk_done;
  logic                   timeout;
  logic                   ph_wrap;

  always_comb begin
    sig_edge   = sync_q[SYNC_STAGES-1] & ~prev_q;
    blk_sum    = sum_q + SumW'(per_cnt_q);
    blk_avg    = CNT_WIDTH'(blk_sum >> AVG_LOG2);
    calc_avg   = CNT_WIDTH'(sum_q >> AVG_LOG2);
    hold_min   = {1'b0, hold_i} + HoldMarg;
    calc_short = {1'b0, calc_avg} < hold_min;
    blk_short  = {1'b0, blk_avg} < hold_min;
    blk_done   = sig_edge && (edge_cnt_q == EcLast);
    // Fires on the cycle per_cnt would step to TIMEOUT; a coincident edge wins.
    timeout    = (per_cnt_q >= TimeoutM1) && !sig_edge;
    ph_wrap    = (ph_cnt_q >= stb_period_q - CNT_WIDTH'(1));
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      per_cnt_q <= '0;
    end else if (state_q == StIdle || state_q == StErr) begin
      per_cnt_q <= '0;
    end else if (sig_edge) begin
      per_cnt_q <= CNT_WIDTH'(1);
    end else if (per_cnt_q != CntMax) begin
      per_cnt_q <= per_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= StIdle;
      sum_q        <= '0;
      edge_cnt_q   <= '0;
      ph_cnt_q     <= '0;
      stb_period_q <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      rdy_q        <= 1'b0;
      err_q        <= 1'b0;
      stb_q        <= 1'b0;
    end else if (!en_i) begin
      state_q      <= StIdle;
      rdy_q        <= 1'b0;
      stb_q        <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StSkip;
          err_q   <= 1'b0;
        end
        StSkip: begin
          if (sig_edge) begin
            state_q    <= StMeas;
            sum_q      <= '0;
            edge_cnt_q <= '0;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end
        end
        StMeas: begin
          if (sig_edge) begin
            sum_q      <= blk_sum;
            edge_cnt_q <= edge_cnt_q + EcW'(1);
            if (edge_cnt_q == EcLast) state_q <= StCalc;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end
        end
        StCalc: begin
          // Edges cannot arrive on consecutive cycles, so the next block starts clean.
          sum_q        <= '0;
          edge_cnt_q   <= '0;
          pend_valid_q <= 1'b0;
          if (calc_short) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end else begin
            stb_period_q <= calc_avg;
            ph_cnt_q     <= '0;
            rdy_q        <= 1'b1;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (timeout || (blk_done && blk_short)) begin
            err_q   <= 1'b1;
            rdy_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= StErr;
          end else begin
            stb_q    <= oe_i & (ph_cnt_q >= hold_i);
            ph_cnt_q <= ph_wrap ? '0 : ph_cnt_q + CNT_WIDTH'(1);
            if (ph_wrap && pend_valid_q) begin
              stb_period_q <= pend_q;
              pend_valid_q <= 1'b0;
            end
            if (sig_edge) begin
              if (blk_done) begin
                sum_q        <= '0;
                edge_cnt_q   <= '0;
                pend_q       <= blk_avg;
                pend_valid_q <= 1'b1;
              end else begin
                sum_q      <= blk_sum;
                edge_cnt_q <= edge_cnt_q + EcW'(1);
              end
            end
          end
        end
        StErr: begin
          rdy_q <= 1'b0;
          stb_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdy_o        = rdy_q;
  assign err_o        = err_q;
  assign stb_o        = stb_q;
  assign stb_period_o = stb_period_q;

endmodule

// File: tb/tb_stb_gen_avg.sv
// Directed bench for stb_gen_avg: lock, averaging, period switch, timeout, limits, reset.
module tb_stb_gen_avg;

  localparam int unsigned CW = 32;
  localparam int unsigned TO = 1000;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic          sig_i;
  logic          en_i;
  logic          oe_i;
  logic [CW-1:0] hold_i;
  logic          rdy_o;
  logic          err_o;
  logic          stb_o;
  logic [CW-1:0] stb_period_o;

  stb_gen_avg #(
    .CNT_WIDTH  (CW),
    .AVG_LOG2   (2),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .sig_i       (sig_i),
    .en_i        (en_i),
    .oe_i        (oe_i),
    .hold_i      (hold_i),
    .rdy_o       (rdy_o),
    .err_o       (err_o),
    .stb_o       (stb_o),
    .stb_period_o(stb_period_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int sig_period = 100;
  bit sig_run = 1'b0;
  int per_q[$];
  int ph = 0;
  int cur = 0;
  int nedges = 0;
  int last_rise = 0;

  bit ok;
  int hi, lo, lat, n0, last, bad, rises_after, iv, highs;
  bit prev_stb, seen_err, seen_rdy, done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Rising edges of sig_i are spaced exactly by the popped/default period in clocks.
  initial begin
    sig_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!sig_run) begin
        sig_i = 1'b0;
        ph = 0;
      end else begin
        if (ph == 0) begin
          cur = (per_q.size() > 0) ? per_q.pop_front() : sig_period;
          sig_i = 1'b1;
          nedges++;
          last_rise = cyc;
        end else if (ph == cur / 2) begin
          sig_i = 1'b0;
        end
        ph = (ph + 1 == cur) ? 0 : ph + 1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_rdy(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      if (rdy_o) found = 1'b1;
    end
  endtask

  task automatic wait_period(input int value, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_i);
      if (stb_period_o == CW'(value)) found = 1'b1;
    end
  endtask

  task automatic measure_pulse(output int h, output int l);
    int i;
    h = 0;
    l = 0;
    i = 0;
    while (stb_o && i < 400) begin @(negedge clk_i); i++; end
    while (!stb_o && i < 800) begin @(negedge clk_i); i++; end
    while (stb_o && i < 1200) begin h++; @(negedge clk_i); i++; end
    while (!stb_o && i < 1600) begin l++; @(negedge clk_i); i++; end
  endtask

  task automatic restart();
    en_i = 1'b0;
    sig_run = 1'b0;
    cycles(4);
    en_i = 1'b1;
    cycles(2);
  endtask

  initial begin
    arstn_i = 1'b0;
    en_i    = 1'b0;
    oe_i    = 1'b0;
    hold_i  = '0;
    cycles(3);
    check("rst_rdy", rdy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_period", stb_period_o, 0);
    arstn_i = 1'b1;

    // Basic lock at period 100, hold 4
    hold_i = 4;
    oe_i = 1'b1;
    en_i = 1'b1;
    cycles(2);
    sig_period = 100;
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t1_lock", ok, 1);
    check("t1_period", stb_period_o, 100);
    check("t1_err", err_o, 0);
    measure_pulse(hi, lo);
    check("t1_high", hi, 96);
    check("t1_low", lo, 4);

    // Averaging with jittered periods
    restart();
    per_q = {99, 101, 99, 101};
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t2_avg_a", stb_period_o, 100);
    restart();
    per_q = {100, 100, 100, 103};
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t2_avg_b", stb_period_o, 100);
    restart();
    per_q = {101, 101, 102, 102};
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t2_avg_c", stb_period_o, 101);

    // Period change while running; strobe periods never shrink below 100
    sig_period = 120;
    last = -1;
    bad = 0;
    rises_after = 0;
    done = 1'b0;
    prev_stb = stb_o;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_i);
      if (stb_o && !prev_stb) begin
        if (last >= 0) begin
          iv = cyc - last;
          if (iv < 100 || iv > 120) bad++;
        end
        last = cyc;
        if (stb_period_o == CW'(120)) rises_after++;
      end
      prev_stb = stb_o;
      if (rises_after >= 2) done = 1'b1;
    end
    check("t3_switch", stb_period_o, 120);
    check("t3_bad_intervals", bad, 0);
    measure_pulse(hi, lo);
    check("t3_high", hi, 116);
    check("t3_low", lo, 4);

    // Timeout: sig_i held low
    sig_run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk_i);
      if (err_o) ok = 1'b1;
    end
    lat = cyc - last_rise;
    check("t4_err", ok, 1);
    // TIMEOUT cycles after the detected edge, plus the synchroniser delay
    check("t4_timeout_lat_in_window", (lat >= 998 && lat <= 1006), 1);
    cycles(2);
    check("t4_stb", stb_o, 0);
    check("t4_rdy", rdy_o, 0);
    en_i = 1'b0;
    cycles(2);
    check("t4_err_held", err_o, 1);
    en_i = 1'b1;
    cycles(2);
    check("t4_err_clr", err_o, 0);
    sig_period = 100;
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t4_relock", stb_period_o, 100);

    // Period too short for hold: error at CALC, never ready
    restart();
    hold_i = 4;
    sig_period = 5;
    sig_run = 1'b1;
    seen_err = 1'b0;
    seen_rdy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (err_o) seen_err = 1'b1;
      if (rdy_o) seen_rdy = 1'b1;
    end
    check("t5_err", seen_err, 1);
    check("t5_rdy_never", seen_rdy, 0);

    // Output disabled: no strobe, but period still tracks
    restart();
    oe_i = 1'b0;
    sig_period = 100;
    sig_run = 1'b1;
    wait_rdy(1000, ok);
    check("t5_oe_lock", ok, 1);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (stb_o) highs++;
    end
    check("t5_oe_stb_low", highs, 0);
    sig_period = 120;
    wait_period(120, 3000, ok);
    check("t5_oe_period", stb_period_o, 120);
    oe_i = 1'b1;

    // Async reset during RUN, then relock after 1+4 edges
    cycles(250);
    check("t6_pre_rdy", rdy_o, 1);
    for (int i = 0; i < 300 && !sig_i; i++) @(negedge clk_i);
    for (int i = 0; i < 300 && sig_i; i++) @(negedge clk_i);
    cycles(2);
    @(posedge clk_i);
    #3;
    arstn_i = 1'b0;
    #1;
    check("t6_rst_rdy", rdy_o, 0);
    check("t6_rst_stb", stb_o, 0);
    check("t6_rst_err", err_o, 0);
    check("t6_rst_period", stb_period_o, 0);
    cycles(3);
    arstn_i = 1'b1;
    n0 = nedges;
    wait_rdy(1000, ok);
    check("t6_relock", ok, 1);
    check("t6_edges", nedges - n0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
